tff_counter: RTL and testbench

//   Parametrised synchronous up/down counter built from a T-flip-flop toggle mask:

---
 rtl/tff_counter.sv | 98 +++++++++
 tb/tb_tff_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// tff_counter: synchronous up/down counter whose state is updated through a
// T-flip-flop toggle mask. Every edge computes the next count, flips exactly
// the bits that differ (q ^ t), and reports the mask that was applied.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   RESET_VAL  value loaded into q by clr
//
// Ports
//   clk      clock; all state updates on the rising edge
//   clr      synchronous active-high reset; overrides every other input
//   en       count enable
//   up_dn    1 = count up, 0 = count down
//   ld       synchronous load of ld_val (beats counting)
//   ld_val   load value; may exceed mod_max
//   mod_max  top of the count range (counts over 0..mod_max)
//   sat      1 = saturate at the range boundary, 0 = wrap
//   ovf_clr  clears the sticky ovf flag
//   q        current count
//   tc       one-cycle pulse after each boundary-event edge
//   ovf      sticky boundary flag
//   toggles  mask of q bits flipped on the last edge
module tff_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] toggles
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] q_q, toggles_q;
  logic             tc_q, ovf_q;

  logic [WIDTH-1:0] next_val;  // target count for this edge
  logic [WIDTH-1:0] t;         // toggle mask applied to q_q
  logic             boundary;  // a step hit the range boundary

  always_comb begin
    next_val = q_q;
    boundary = 1'b0;
    if (ld) begin
      next_val = ld_val;
    end else if (en) begin
      if (up_dn) begin
        // q above mod_max also counts as a boundary when counting up
        if (q_q < mod_max) begin
          next_val = q_q + One;
        end else begin
          boundary = 1'b1;
          next_val = sat ? mod_max : '0;
        end
      end else begin
        // Down-count is unrestricted by mod_max unless q is already 0
        if (q_q != '0) begin
          next_val = q_q - One;
        end else begin
          boundary = 1'b1;
          next_val = sat ? '0 : mod_max;
        end
      end
    end
    t = q_q ^ next_val;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q       <= RESET_VAL;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      toggles_q <= '0;
    end else begin
      q_q       <= q_q ^ t;
      toggles_q <= t;
      tc_q      <= boundary;
      // Set wins over a coincident clear
      ovf_q     <= boundary | (ovf_q & ~ovf_clr);
    end
  end

  assign q       = q_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign toggles = toggles_q;

endmodule

// File: tb/tb_tff_counter.sv
module tb_tff_counter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1, en = 1'b0, up_dn = 1'b1, ld = 1'b0, sat = 1'b0, ovf_clr = 1'b0;
  logic [W-1:0] ld_val = '0, mod_max = '0;
  logic [W-1:0] q, toggles;
  logic         tc, ovf;

  tff_counter #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .up_dn  (up_dn),
    .ld     (ld),
    .ld_val (ld_val),
    .mod_max(mod_max),
    .sat    (sat),
    .ovf_clr(ovf_clr),
    .q      (q),
    .tc     (tc),
    .ovf    (ovf),
    .toggles(toggles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         ovf;
    logic [W-1:0] tog;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state, plain integers
  int m_q   = 0;
  int m_tc  = 0;
  int m_ovf = 0;
  int m_tog = 0;

  task automatic model_step();
    int nq;
    int bnd;
    int mm;
    nq  = m_q;
    bnd = 0;
    mm  = int'(mod_max);
    if (clr) begin
      m_q = 0; m_tc = 0; m_ovf = 0; m_tog = 0;
    end else begin
      if (ld) nq = int'(ld_val);
      else if (en) begin
        if (up_dn) begin
          if (m_q < mm) nq = m_q + 1;
          else begin bnd = 1; nq = sat ? mm : 0; end
        end else begin
          if (m_q > 0) nq = m_q - 1;
          else begin bnd = 1; nq = sat ? 0 : mm; end
        end
      end
      m_tog = m_q ^ nq;
      m_tc  = bnd;
      m_ovf = (bnd != 0 || (m_ovf != 0 && !ovf_clr)) ? 1 : 0;
      m_q   = nq;
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lv, input logic [W-1:0] mm, input logic s,
                       input logic oc);
    exp_t x;
    @(negedge clk);
    clr = c; en = e; up_dn = u; ld = l; ld_val = lv; mod_max = mm; sat = s; ovf_clr = oc;
    model_step();
    x.q   = W'(m_q);
    x.tc  = (m_tc != 0);
    x.ovf = (m_ovf != 0);
    x.tog = W'(m_tog);
    sb.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: one output sample per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q", q, e.q);
        check("tc", {7'b0, tc}, {7'b0, e.tc});
        check("ovf", {7'b0, ovf}, {7'b0, e.ovf});
        check("toggles", toggles, e.tog);
      end
    end
  end

  initial begin
    //         clr  en   up   ld   ld_val mod_max sat  ovf_clr
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    // clr mid-count, held two edges, then resume
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h37, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    // mod 10 wrap
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0);
    repeat (12) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0);
    // load 3, saturating down-count pinned at 0
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h09, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h09, 1'b1, 1'b0);
    // load beats count
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0);
    // q above mod_max
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 8'h05, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 8'h05, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0);
    // ovf set beats clear, then clear alone
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0, 1'b1);
    // mod_max = 0 pins the count at 0
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized traffic, biased toward small ranges so boundaries are hit often
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] mm, lv;
      mm = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 14));
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 6, lv, mm, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 5);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
